// File: rtl/n_bit_serializer_pkg.sv
// Framing definitions shared by the serializer and the future deserializer,
// so both ends agree on state encoding and line levels.
package n_bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Line level driven while in state s; data_bit is the current LSB of the frame.
  function automatic logic line_level(input state_t s, input logic data_bit);
    logic lvl;
    lvl = IDLE_LEVEL;
    case (s)
      START:   lvl = START_BIT;
      DATA:    lvl = data_bit;
      STOP:    lvl = STOP_BIT;
      default: lvl = IDLE_LEVEL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/n_bit_serializer_bit_counter.sv
// Up-counter with synchronous clear and enable; clear has priority over enable.
// Shared with the receiver side for counting data bits.
module bit_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/n_bit_serializer.sv
// Parallel-to-serial transmitter: start bit, n data bits LSB first, stop bit.
// Accepts a word only while idle; all outputs come straight from registers.
module n_bit_serializer
  import n_bit_serializer_pkg::*;
#(
  parameter int n = 5
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic [n-1:0] D,
  input  logic         load,
  output logic         ready,
  output logic         sout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(n);
  localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);

  state_t        state_reg, state_next;
  logic [n-1:0]  shift_reg, shift_next;
  logic          sout_reg, sout_next;
  logic [CW-1:0] bit_cnt;
  logic          cnt_clr, cnt_en;

  bit_counter #(.CW(CW)) u_bit_counter (
    .clk   (clk),
    .rst   (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (bit_cnt)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_clr    = 1'b1;
    cnt_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          shift_next = D;
          state_next = START;
        end
      end
      START: state_next = DATA;
      DATA: begin
        cnt_clr    = 1'b0;
        shift_next = {1'b0, shift_reg[n-1:1]};
        // Counter holds the index of the bit currently on the line.
        if (bit_cnt == LAST_BIT) begin
          state_next = STOP;
          cnt_clr    = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      STOP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    sout_next = line_level(state_next, shift_next[0]);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      sout_reg  <= IDLE_LEVEL;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      sout_reg  <= sout_next;
    end
  end

  assign sout  = sout_reg;
  assign ready = (state_reg == IDLE);
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == STOP);

endmodule

// File: tb/tb_n_bit_serializer.sv
// Directed bench for n_bit_serializer: a frame-level queue model checked every
// cycle, plus literal expectations for each directed frame.
module tb_n_bit_serializer;

  localparam int N = 5;
  // {sout, ready, busy, done}
  localparam logic [3:0] IDLE_EXP  = 4'b1100;
  localparam logic [3:0] START_EXP = 4'b0010;
  localparam logic [3:0] STOP_EXP  = 4'b1011;

  logic         clk = 1'b0;
  logic         Reset;
  logic [N-1:0] D;
  logic         load;
  logic         ready, sout, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] cur;
  logic [3:0] q[$];

  n_bit_serializer #(.n(N)) dut (
    .clk   (clk),
    .Reset (Reset),
    .D     (D),
    .load  (load),
    .ready (ready),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: an accepted load queues the whole expected waveform.
  initial begin
    cur = IDLE_EXP;
    forever begin
      @(posedge clk or posedge Reset);
      if (Reset) begin
        q.delete();
        cur = IDLE_EXP;
      end else begin
        if (cur == IDLE_EXP && q.size() == 0 && load) begin
          q.push_back(START_EXP);
          for (int i = 0; i < N; i++) q.push_back({D[i], 3'b010});
          q.push_back(STOP_EXP);
        end
        if (q.size() > 0) cur = q.pop_front();
        else cur = IDLE_EXP;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_sout",  {31'd0, sout},  {31'd0, cur[3]});
      check("model_ready", {31'd0, ready}, {31'd0, cur[2]});
      check("model_busy",  {31'd0, busy},  {31'd0, cur[1]});
      check("model_done",  {31'd0, done},  {31'd0, cur[0]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Records sout over len cycles; optionally drives load/D after sample inj_at
  // (load dropped again after the following sample) or inverts D every cycle.
  task automatic capture(input int len, input int inj_at, input logic inj_load,
                         input logic [N-1:0] inj_d, input bit toggle,
                         output logic [14:0] seq, output int dones, output int rlow);
    seq   = '0;
    dones = 0;
    rlow  = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      #1;
      seq[i] = sout;
      dones += int'(done);
      rlow  += int'(!ready);
      if (i == inj_at) begin
        load = inj_load;
        D    = inj_d;
      end else if (inj_at >= 0 && i == inj_at + 1) begin
        load = 1'b0;
      end
      if (toggle) D = ~D;
    end
  endtask

  task automatic send(input logic [N-1:0] d);
    D    = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  logic [14:0] seq;
  int dn, rl;

  initial begin
    Reset = 1'b0;
    load  = 1'b0;
    D     = '0;
    #1 Reset = 1'b1;

    // Reset held for about 40 ns
    @(negedge clk); #1;
    check("rst_during", {28'd0, sout, ready, busy, done}, 32'hC);
    repeat (4) tick();
    Reset = 1'b0;
    tick();
    check("rst_after", {28'd0, sout, ready, busy, done}, 32'hC);
    $display("reset: sout=%b ready=%b busy=%b done=%b", sout, ready, busy, done);

    // Single frame
    send(5'b10110);
    capture(7, -1, 1'b0, '0, 1'b0, seq, dn, rl);
    check("single_seq", {25'd0, seq[6:0]}, 32'b1101100);
    check("single_done", dn, 1);
    check("single_ready_low", rl, 7);
    $display("single frame D=10110: seq=%b dones=%0d ready_low=%0d", seq[6:0], dn, rl);
    repeat (2) tick();

    // Load during DATA is ignored
    send(5'b01110);
    capture(7, 2, 1'b1, 5'b10101, 1'b0, seq, dn, rl);
    check("ignored_seq", {25'd0, seq[6:0]}, 32'b1011100);
    check("ignored_done", dn, 1);
    capture(4, -1, 1'b0, 5'b10101, 1'b0, seq, dn, rl);
    check("ignored_idle", {28'd0, seq[3:0]}, 32'hF);
    check("ignored_nodone", dn, 0);
    $display("ignored load: second word not sent, idle seq=%b", seq[3:0]);
    repeat (2) tick();

    // Back-to-back with load held high
    D    = 5'b10101;
    load = 1'b1;
    tick();
    D = 5'b01110;
    capture(15, 13, 1'b0, 5'b01110, 1'b0, seq, dn, rl);
    check("b2b_seq", {17'd0, seq}, 32'b101110011101010);
    check("b2b_done", dn, 2);
    $display("back-to-back: seq=%b dones=%0d", seq, dn);
    repeat (2) tick();

    // Reset at the third data bit, with load also high during reset
    send(5'b10110);
    capture(4, -1, 1'b0, '0, 1'b0, seq, dn, rl);
    check("abort_pre", {28'd0, seq[3:0]}, 32'b1100);
    #1 Reset = 1'b1;
    #1;
    check("abort_async", {28'd0, sout, ready, busy, done}, 32'hC);
    load = 1'b1;
    D    = 5'b11111;
    tick();
    tick();
    load  = 1'b0;
    Reset = 1'b0;
    capture(3, -1, 1'b0, 5'b11111, 1'b0, seq, dn, rl);
    check("abort_nodone", dn, 0);
    check("abort_idle", {29'd0, seq[2:0]}, 32'b111);
    repeat (2) tick();
    send(5'b11111);
    capture(7, -1, 1'b0, '0, 1'b0, seq, dn, rl);
    check("after_abort_seq", {25'd0, seq[6:0]}, 32'b1111110);
    check("after_abort_done", dn, 1);
    $display("reset mid-frame then D=11111: seq=%b", seq[6:0]);
    repeat (2) tick();

    // D toggling after capture does not disturb the frame
    send(5'b00001);
    capture(7, -1, 1'b0, '0, 1'b1, seq, dn, rl);
    check("isolate_seq", {25'd0, seq[6:0]}, 32'b1000010);
    check("isolate_done", dn, 1);
    $display("capture isolation D=00001: seq=%b", seq[6:0]);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
